ledg_sequencer: RTL
===================

// Module: ledg_sequencer
// PURPOSE
//  Avalon-MM controller that drives the green-LED PIO without CPU involvement: it plays
//  a programmable table of up to DEPTH patterns, one per PERIOD clock ticks, by issuing
//  writes to the PIO's s1 data register (address 0). Software configures it through a
//  zero-wait-state Avalon-MM slave and can run it looped or one-shot.
// PARAMETERS
//  DATA_W    9   LED pattern width; matches the PIO data register width
//  DEPTH     8   pattern table entries (power of 2, max 16); IDX_W = clog2(DEPTH)
//  PERIOD_W  24  width of the step-period counter
// PORTS
//  clk           in   1   system clock; the only clock
//  reset         in   1   asynchronous, active-high reset
//  s_address     in   5   config slave word address
//  s_chipselect  in   1   config slave select
//  s_write_n     in   1   config slave write strobe, active low
//  s_writedata   in   32  config write data
//  s_readdata    out  32  config read data; combinational from s_address, zero wait
//  m_address     out  2   master address to the PIO; constant 0
//  m_chipselect  out  1   master write request
//  m_write_n     out  1   active low; equals ~m_chipselect
//  m_writedata   out  32  {(32-DATA_W) zeros, pattern}
//  m_waitrequest in   1   fabric stall; a write is accepted on m_chipselect & ~m_waitrequest
// BEHAVIOUR
//  Register map (word address):
//   0 CTRL   [0] run, [1] oneshot, [IDX_W+3:4] last index (table length - 1); R/W
//   1 PERIOD [PERIOD_W-1:0] ticks per step; 0 is treated as 1; R/W
//   2 STATUS [0] busy (state!=IDLE), [IDX_W+3:4] current index, [8] done (sticky, W1C); RO
//   16..16+DEPTH-1 TABLE[i] [DATA_W-1:0]; R/W; unused and out-of-range addresses read 0
//  Reset: all registers, index, counter and done clear to 0; state IDLE; m_chipselect=0,
//   m_write_n=1, m_writedata=0, m_address=0.
//  FSM IDLE -> WRITE -> WAIT -> WRITE ... :
//   IDLE : on a CTRL write with run=1: index<=0 and go to WRITE. m_chipselect rises in the
//          cycle after the slave write.
//   WRITE: hold m_chipselect=1 and m_writedata=TABLE[index] stable until accepted. Then load
//          the counter with max(PERIOD,1) and go to WAIT, or go to IDLE if run=0.
//   WAIT : decrement the counter each cycle. At 1, take one of three actions:
//          - index != last: index+1, go to WRITE.
//          - index == last and oneshot=0: wrap index to 0, go to WRITE.
//          - index == last and oneshot=1: set done, clear CTRL.run, go to IDLE.
//  Timing: with m_waitrequest=0, consecutive accepted writes are max(PERIOD,1)+1 cycles apart.
//  Mid-operation changes:
//   - run cleared during WRITE: the current transfer completes; it is never dropped mid-request.
//   - run cleared during WAIT: go to IDLE the next cycle; no further writes.
//   - Table, PERIOD and last-index writes while running take effect at the next fetch or counter load.
//   - A CTRL run=1 write while already busy does not restart the sequence.
//   - last > DEPTH-1 is clamped to DEPTH-1.
//  Simultaneous events: a done-set in the same cycle as a W1C done-clear leaves done=1.
//  Reset asserted mid-transfer: master outputs drop immediately (async); the fabric is
//   reset by the same source.
// STRUCTURE
//  Shared include ledg_seq_defs.vh holds:
//   - register offsets (CTRL, PERIOD, STATUS, TABLE_BASE)
//   - CTRL and STATUS bit positions
//   - FSM state encodings (IDLE=0, WRITE=1, WAIT=2)
//  One sub-module: ledg_seq_timer, the PERIOD_W down-counter with load/enable inputs and a
//   zero-clamp, providing the 'expire' output.
//  The pattern table is a DEPTH x DATA_W register file in this module (no RAM inference).
// TESTING
//  1 Set TABLE[0..2]=0x001,0x002,0x004, PERIOD=3, CTRL=run|last=2, no stalls ->
//    m_writedata 0x001,0x002,0x004,0x001... with acceptances exactly 4 cycles apart.
//  2 As test 1 with oneshot=1 -> exactly 3 writes; then STATUS.done=1, busy=0, CTRL.run=0;
//    writing 0x100 to STATUS clears done.
//  3 m_waitrequest held high 5 cycles on the 2nd write -> m_chipselect and m_writedata=0x002
//    held stable throughout; the next write comes max(PERIOD,1)+1 cycles after acceptance.
//  4 Clear run during WRITE under waitrequest -> that write completes, then IDLE.
//    Clear run during WAIT -> no further m_chipselect.
//  5 PERIOD=0, last=0, TABLE[0]=0x1FF, looped -> 0x1FF rewritten every 2 cycles.
//    Readback of addr 24+ = 0.
//  6 Assert reset mid-WAIT and mid-WRITE -> all outputs and STATUS return to reset values
//    asynchronously; after release, no writes occur until run is written again.

Source files
------------

// File: rtl/ledg_sequencer_pkg.sv
// Register map, control/status bit positions and FSM encoding shared by the LED sequencer.
// Constants only; no logic.
package ledg_sequencer_pkg;

   localparam int ADDR_CTRL       = 0;
   localparam int ADDR_PERIOD     = 1;
   localparam int ADDR_STATUS     = 2;
   localparam int ADDR_TABLE_BASE = 16;

   localparam int CTRL_RUN      = 0;
   localparam int CTRL_ONESHOT  = 1;
   localparam int CTRL_LAST_LSB = 4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_IDX_LSB = 4;
   localparam int STAT_DONE    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/ledg_seq_timer.sv
// Step-period down-counter: load takes max(period,1), expire flags the final counted cycle.
// Expire is combinational from the count while enabled; no backpressure.
module ledg_seq_timer #(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                en,
   input  logic [PERIOD_W-1:0] period,
   output logic                expire
);

   logic [PERIOD_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= (period == '0) ? PERIOD_W'(1) : period;
      end else if (en && (count > PERIOD_W'(1))) begin
         count <= count - 1'b1;
      end
   end

   assign expire = en && (count <= PERIOD_W'(1));

endmodule

// File: rtl/ledg_sequencer.sv
// Plays a pattern table into the LED PIO data register, one Avalon-MM write per step period.
// Request rises the cycle after a run write and holds, data stable, until m_waitrequest drops.
module ledg_sequencer
   import ledg_sequencer_pkg::*;
#(
   parameter int DATA_W   = 9,
   parameter int DEPTH    = 8,
   parameter int PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t              state, state_nxt;
   logic                run, oneshot, done;
   logic [IDX_W-1:0]    last, last_wr, index, index_nxt;
   logic [PERIOD_W-1:0] period;
   logic [DATA_W-1:0]   tbl [DEPTH];
   logic [DATA_W-1:0]   dat_q;
   logic                wr, ctrl_wr, tbl_hit;
   logic                fetch, tmr_load, expire, done_set;
   logic [3:0]          last_field;
   logic                unused_wd;

   assign wr         = s_chipselect & ~s_write_n;
   assign ctrl_wr    = wr && (s_address == 5'(ADDR_CTRL));
   assign tbl_hit    = s_address[4] && ({1'b0, s_address[3:0]} < 5'(DEPTH));
   assign last_field = s_writedata[CTRL_LAST_LSB +: 4];
   assign last_wr    = (last_field > 4'(DEPTH-1)) ? IDX_W'(DEPTH-1) : last_field[IDX_W-1:0];
   assign unused_wd  = ^s_writedata;

   ledg_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (tmr_load),
      .en     (state == ST_WAIT),
      .period (period),
      .expire (expire)
   );

   always_comb begin
      state_nxt = state;
      index_nxt = index;
      fetch     = 1'b0;
      tmr_load  = 1'b0;
      done_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl_wr && s_writedata[CTRL_RUN]) begin
               index_nxt = '0;
               fetch     = 1'b1;
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // The transfer is never abandoned; run is only consulted once it is accepted.
            if (!m_waitrequest) begin
               if (run) begin
                  tmr_load  = 1'b1;
                  state_nxt = ST_WAIT;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (!run) begin
               state_nxt = ST_IDLE;
            end else if (expire) begin
               if (index != last) begin
                  index_nxt = index + 1'b1;
                  fetch     = 1'b1;
                  state_nxt = ST_WRITE;
               end else if (!oneshot) begin
                  index_nxt = '0;
                  fetch     = 1'b1;
                  state_nxt = ST_WRITE;
               end else begin
                  done_set  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Pattern is captured at fetch so table writes cannot disturb a stalled request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         index <= '0;
         dat_q <= '0;
      end else begin
         state <= state_nxt;
         index <= index_nxt;
         if (fetch) dat_q <= tbl[index_nxt];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run     <= 1'b0;
         oneshot <= 1'b0;
         last    <= '0;
         period  <= '0;
         done    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else begin
         if (done_set) begin
            run <= 1'b0;
         end else if (ctrl_wr) begin
            run <= s_writedata[CTRL_RUN];
         end
         if (ctrl_wr) begin
            oneshot <= s_writedata[CTRL_ONESHOT];
            last    <= last_wr;
         end
         if (wr && (s_address == 5'(ADDR_PERIOD))) period <= s_writedata[PERIOD_W-1:0];
         if (done_set) begin
            done <= 1'b1;
         end else if (wr && (s_address == 5'(ADDR_STATUS)) && s_writedata[STAT_DONE]) begin
            done <= 1'b0;
         end
         if (wr && tbl_hit) tbl[s_address[IDX_W-1:0]] <= s_writedata[DATA_W-1:0];
      end
   end

   always_comb begin
      s_readdata = '0;
      if (s_address == 5'(ADDR_CTRL)) begin
         s_readdata[CTRL_RUN]                 = run;
         s_readdata[CTRL_ONESHOT]             = oneshot;
         s_readdata[CTRL_LAST_LSB +: IDX_W]   = last;
      end else if (s_address == 5'(ADDR_PERIOD)) begin
         s_readdata[PERIOD_W-1:0]             = period;
      end else if (s_address == 5'(ADDR_STATUS)) begin
         s_readdata[STAT_BUSY]                = (state != ST_IDLE);
         s_readdata[STAT_IDX_LSB +: IDX_W]    = index;
         s_readdata[STAT_DONE]                = done;
      end else if (tbl_hit) begin
         s_readdata[DATA_W-1:0]               = tbl[s_address[IDX_W-1:0]];
      end
   end

   assign m_address    = 2'b00;
   assign m_chipselect = (state == ST_WRITE);
   assign m_write_n    = ~m_chipselect;
   assign m_writedata  = m_chipselect ? {{(32-DATA_W){1'b0}}, dat_q} : 32'd0;

endmodule
